// File: rtl/fp_mult_arbiter.sv
// Round-robin, credit-based sharing of one pipelined FP32 multiplier among N_REQ requesters.
// Optional per-requester sticky status accumulation is built when FPM_STICKY_EN is defined.
module fp_mult_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MUL_LAT   = 2,
  parameter int RSP_DEPTH = 4,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [3*N_REQ-1:0]   req_rnd,
  output logic                 mul_valid,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic [2:0]           mul_rnd,
  input  logic [31:0]          mul_z,
  input  logic [7:0]           mul_status,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_z,
  output logic [7:0]           rsp_status,
  output logic                 status_err,
  output logic [5*N_REQ-1:0]   sticky_flags,
  input  logic [N_REQ-1:0]     sticky_clr
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  rr_ptr_reg;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic             credit_ok;
  int               outstanding;

  logic [MUL_LAT-1:0] tag_valid_reg;
  logic [ID_W-1:0]    tag_id_reg [MUL_LAT];

  logic [ID_W-1:0]  fifo_id_mem     [RSP_DEPTH];
  logic [31:0]      fifo_z_mem      [RSP_DEPTH];
  logic [7:0]       fifo_status_mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;
  logic [ID_W-1:0]  push_id;
  logic [4:0]       push_flags;
  logic             multi_flag;
  logic             status_err_reg;

  // Every in-flight tag already owns a FIFO slot, so issue is limited by tags plus occupancy.
  always_comb begin
    outstanding = int'(count_reg);
    for (int s = 0; s < MUL_LAT; s++) begin
      outstanding = outstanding + int'(tag_valid_reg[s]);
    end
  end

  assign credit_ok = (outstanding < RSP_DEPTH);

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int cand;
      cand = int'(rr_ptr_reg) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_any && req_valid[ID_W'(cand)]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(cand);
      end
    end
    if (rst || !credit_ok) grant_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    mul_rnd   = '0;
    if (grant_any) req_ready[grant_id] = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        mul_a   = req_a[32*k +: 32];
        mul_b   = req_b[32*k +: 32];
        mul_rnd = req_rnd[3*k +: 3];
      end
    end
  end

  assign mul_valid = grant_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_any) begin
      rr_ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipeline mirrors the multiplier latency so the tail stage lines up with mul_z.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg[0] <= 1'b0;
    end else begin
      tag_valid_reg[0] <= grant_any;
      tag_id_reg[0]    <= grant_id;
    end
  end

  for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (rst) begin
        tag_valid_reg[gi] <= 1'b0;
      end else begin
        tag_valid_reg[gi] <= tag_valid_reg[gi-1];
        tag_id_reg[gi]    <= tag_id_reg[gi-1];
      end
    end
  end

  assign push       = tag_valid_reg[MUL_LAT-1];
  assign push_id    = tag_id_reg[MUL_LAT-1];
  assign push_flags = mul_status[4:0];
  assign multi_flag = |(push_flags & (push_flags - 5'd1));
  assign rsp_valid  = (count_reg != '0);
  assign pop        = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_mem[wr_ptr_reg]     <= push_id;
      fifo_z_mem[wr_ptr_reg]      <= mul_z;
      fifo_status_mem[wr_ptr_reg] <= mul_status;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rsp_id     = fifo_id_mem[rd_ptr_reg];
  assign rsp_z      = fifo_z_mem[rd_ptr_reg];
  assign rsp_status = fifo_status_mem[rd_ptr_reg];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_reg == CNT_W'(RSP_DEPTH))));

  always_ff @(posedge clk) begin
    if (rst) begin
      status_err_reg <= 1'b0;
    end else if (push && multi_flag) begin
      status_err_reg <= 1'b1;
    end
  end

  assign status_err = status_err_reg;

`ifdef FPM_STICKY_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sticky
    logic [4:0] flags_reg;
    // Clear has priority over a same-cycle accumulate.
    always_ff @(posedge clk) begin
      if (rst || sticky_clr[gi]) begin
        flags_reg <= '0;
      end else if (push && (push_id == ID_W'(gi))) begin
        flags_reg <= flags_reg | push_flags;
      end
    end
    assign sticky_flags[5*gi +: 5] = flags_reg;
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = ^sticky_clr;
  assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with a fixed-latency multiplier stand-in.
module tb_fp_mult_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [3*N-1:0] req_rnd;
  logic           mul_valid;
  logic [31:0]    mul_a;
  logic [31:0]    mul_b;
  logic [2:0]     mul_rnd;
  logic [31:0]    mul_z;
  logic [7:0]     mul_status;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_z;
  logic [7:0]     rsp_status;
  logic           status_err;
  logic [5*N-1:0] sticky_flags;
  logic [N-1:0]   sticky_clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  stat_next;
  logic [31:0] z_d1, z_d2;
  logic [7:0]  s_d1, s_d2;

  logic [31:0] op_a  [4] = '{32'h0000A0A0, 32'h0000A0A1, 32'h0000A0A2, 32'h0000A0A3};
  logic [31:0] op_b  [4] = '{32'h0000B0B0, 32'h0000B0B1, 32'h0000B0B2, 32'h0000B0B3};
  logic [2:0]  op_r  [4] = '{3'd1, 3'd3, 3'd5, 3'd7};
  logic [31:0] exp_z [4] = '{32'hA0A0B0B0, 32'hA0A1B0B1, 32'hA0A2B0B2, 32'hA0A3B0B3};
  logic [3:0]  rr_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]  rr_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0]  bp_g  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0]  dr_g  [2] = '{4'b0000, 4'b0001};
  int gcnt;

  fp_mult_arbiter #(.N_REQ(N), .MUL_LAT(LAT), .RSP_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
    .mul_z(mul_z), .mul_status(mul_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_status(rsp_status),
    .status_err(status_err), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  // Known product for the one real FP vector; otherwise an operand-derived stand-in.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
    return {a[15:0], b[15:0]};
  endfunction

  always @(posedge clk) begin
    z_d1 <= mul_valid ? fmul(mul_a, mul_b) : 32'h0;
    s_d1 <= mul_valid ? stat_next : 8'h0;
    z_d2 <= z_d1;
    s_d2 <= s_d1;
  end
  assign mul_z      = z_d2;
  assign mul_status = s_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
      req_rnd[3*i +: 3] = op_r[i];
    end
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  // Single issue from a requester with a chosen status; returns at the negedge one cycle later.
  task automatic issue1(input logic [3:0] req, input logic [7:0] stat, input string tag);
    nxt();
    req_valid = req;
    stat_next = stat;
    smp();
    chk(tag, req_ready, req);
    $display("issue %s grant=%b", tag, req_ready);
    nxt();
    req_valid = '0;
    stat_next = 8'h00;
    smp();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; sticky_clr = '0; stat_next = 8'h00;
    load_ops();

    // Reset state with requests pending
    nxt();
    req_valid = 4'hF;
    smp();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_status_err", status_err, 0);
    chk("rst_sticky", sticky_flags, 0);
    nxt();
    rst = 1'b0;

    // Single request from requester 2: 1.5 * 2.0 = 3.0
    req_valid = 4'b0000;
    req_a[64 +: 32] = 32'h3FC00000;
    req_b[64 +: 32] = 32'h40000000;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    smp();
    chk("t1_grant", req_ready, 4'b0100);
    chk("t1_mul_valid", mul_valid, 1);
    chk("t1_mul_a", mul_a, 32'h3FC00000);
    chk("t1_mul_b", mul_b, 32'h40000000);
    chk("t1_mul_rnd", mul_rnd, 3'd5);
    nxt(); req_valid = '0; smp();
    chk("t1_lat1", rsp_valid, 0);
    nxt(); smp();
    chk("t1_lat2", rsp_valid, 0);
    nxt(); smp();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 2'd2);
    chk("t1_rsp_z", rsp_z, 32'h40400000);
    chk("t1_rsp_zero", rsp_status[0], 0);
    $display("t1 rsp id=%0d z=%h", rsp_id, rsp_z);
    nxt(); smp();
    chk("t1_popped", rsp_valid, 0);
    load_ops();

    // Round robin with all requesters active
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      smp();
      if (k < 5) chk("rr_grant", req_ready, rr_g[k]);
      if (k >= 3) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_id", rsp_id, rr_id[k-3]);
        chk("rr_rsp_z", rsp_z, exp_z[rr_id[k-3]]);
      end
      $display("rr cycle %0d grant=%b rsp_valid=%0d id=%0d", k, req_ready, rsp_valid, rsp_id);
      nxt();
      if (k == 4) req_valid = '0;
    end
    smp();
    chk("rr_drained", rsp_valid, 0);

    // Backpressure: credits cap grants at the FIFO depth
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    gcnt = 0;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("bp_grant", req_ready, bp_g[k]);
      if (req_ready != '0) gcnt++;
      $display("bp cycle %0d grant=%b", k, req_ready);
      nxt();
    end
    chk("bp_total", gcnt, 4);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      if (k < 2) chk("dr_grant", req_ready, dr_g[k]);
      chk("dr_rsp_valid", rsp_valid, 1);
      chk("dr_rsp_id", rsp_id, rr_id[k]);
      chk("dr_rsp_z", rsp_z, exp_z[rr_id[k]]);
      $display("drain %0d grant=%b id=%0d z=%h", k, req_ready, rsp_id, rsp_z);
      nxt();
      if (k == 1) req_valid = '0;
    end
    smp();
    chk("dr_empty", rsp_valid, 0);

    // Illegal status combination is sticky
    issue1(4'b0010, 8'h05, "st_grant_a");
    nxt(); smp();
    chk("st_err_before", status_err, 0);
    nxt(); smp();
    chk("st_err_set", status_err, 1);
    chk("st_rsp_status", rsp_status, 8'h05);
    chk("st_rsp_id", rsp_id, 2'd1);
    issue1(4'b0010, 8'h01, "st_grant_b");
    nxt(); nxt(); smp();
    chk("st_rsp_status2", rsp_status, 8'h01);
    chk("st_err_hold", status_err, 1);
    nxt(); nxt(); smp();
    chk("st_err_hold2", status_err, 1);

`ifdef FPM_STICKY_EN
    do_reset();
    issue1(4'b0010, 8'h01, "sk_grant_a");
    nxt(); nxt(); smp();
    chk("sk_after_a", sticky_flags, 20'h00020);
    issue1(4'b0010, 8'h10, "sk_grant_b");
    nxt(); nxt(); smp();
    chk("sk_after_b", sticky_flags[9:5], 5'b10001);
    chk("sk_after_b_all", sticky_flags, 20'h00220);
    issue1(4'b0010, 8'h02, "sk_grant_c");
    nxt();
    sticky_clr = 4'b0010;
    smp();
    chk("sk_before_clr", sticky_flags[9:5], 5'b10001);
    nxt();
    sticky_clr = '0;
    smp();
    chk("sk_clr_wins", sticky_flags, 0);
`else
    chk("sk_disabled", sticky_flags, 0);
`endif

    // Reset with two operations in flight and one result queued
    do_reset();
    rsp_ready = 1'b0;
    nxt();
    req_valid = 4'b0110;
    stat_next = 8'h00;
    smp();
    chk("rs_grant0", req_ready, 4'b0010);
    nxt(); smp();
    chk("rs_grant1", req_ready, 4'b0100);
    nxt(); smp();
    chk("rs_grant2", req_ready, 4'b0010);
    nxt();
    req_valid = '0;
    rst = 1'b1;
    smp();
    chk("rs_queued", rsp_valid, 1);
    nxt();
    rst = 1'b0;
    smp();
    chk("rs_rsp_valid", rsp_valid, 0);
    chk("rs_mul_valid", mul_valid, 0);
    nxt(); smp();
    chk("rs_discard1", rsp_valid, 0);
    nxt(); smp();
    chk("rs_discard2", rsp_valid, 0);
    nxt();
    req_valid = 4'hF;
    smp();
    chk("rs_next_grant", req_ready, 4'b0001);
    $display("post-reset grant=%b", req_ready);
    nxt();
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
